// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM states and the
// RV32I load/store width codes used by both the responder and the control unit.
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

endpackage

// File: rtl/lsu_align.sv
// Combinational load/store alignment: byte-lane select, write mask,
// sign/zero extension and misalignment / illegal-code detection.
// Operates on one 4-byte aligned word; offset is the byte within that word.
module lsu_align
   import dmem_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  we,
   input  logic [2:0]            funct3,
   input  logic [1:0]            offset,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [DATA_WIDTH-1:0] rword,
   output logic                  err,
   output logic [3:0]            wmask,
   output logic [DATA_WIDTH-1:0] wlanes,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] shifted;

   assign shifted = rword >> {offset, 3'b000};
   assign wlanes  = wdata << {offset, 3'b000};

   // Flag misaligned halfword/word accesses and codes that are not legal for the direction
   always_comb begin
      err = 1'b0;
      case (funct3)
         F3_LB:   err = 1'b0;
         F3_LH:   err = offset[0];
         F3_LW:   err = |offset;
         F3_LBU:  err = we;
         F3_LHU:  err = we | offset[0];
         default: err = 1'b1;
      endcase
   end

   // Select the byte lanes a legal store touches; loads and errors write nothing
   always_comb begin
      wmask = 4'b0000;
      if (we && !err) begin
         case (funct3)
            F3_SB:   wmask = 4'b0001 << offset;
            F3_SH:   wmask = 4'b0011 << offset;
            F3_SW:   wmask = 4'b1111;
            default: wmask = 4'b0000;
         endcase
      end
   end

   // Extract and extend load data; stores and errors return zero
   always_comb begin
      rdata = '0;
      if (!we && !err) begin
         case (funct3)
            F3_LB:   rdata = {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
            F3_LH:   rdata = {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
            F3_LW:   rdata = shifted;
            F3_LBU:  rdata = {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]};
            F3_LHU:  rdata = {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]};
            default: rdata = '0;
         endcase
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data memory responder: accepts one request, waits WAIT_STATES
// cycles, performs the access on the edge entering RESP and pulses a response.
// Storage is a little-endian byte array that survives reset.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int ADDRESS_WIDTH = 32,
   parameter int DATA_WIDTH    = 32,
   parameter int MEM_ADDR_BITS = 12,
   parameter int WAIT_STATES   = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic                     req_we,
   input  logic [ADDRESS_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0]    req_wdata,
   input  logic [2:0]               req_funct3,
   output logic                     resp_valid,
   output logic [DATA_WIDTH-1:0]    resp_rdata,
   output logic                     resp_err,
   output logic                     stall
);

   localparam int         MEM_BYTES = 1 << MEM_ADDR_BITS;
   localparam logic [3:0] CNT_INIT  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   state_t                   state;
   state_t                   next_state;
   logic [3:0]               cnt;
   logic                     accept;
   logic                     enter_resp;

   logic                     we_q;
   logic [MEM_ADDR_BITS-1:0] addr_q;
   logic [DATA_WIDTH-1:0]    wdata_q;
   logic [2:0]               funct3_q;
   logic [DATA_WIDTH-1:0]    rdata_q;

   logic                     op_we;
   logic [MEM_ADDR_BITS-1:0] op_addr;
   logic [DATA_WIDTH-1:0]    op_wdata;
   logic [2:0]               op_funct3;

   logic [7:0]               mem [MEM_BYTES];
   logic [DATA_WIDTH-1:0]    rword;
   logic [DATA_WIDTH-1:0]    wlanes;
   logic [DATA_WIDTH-1:0]    load_data;
   logic [3:0]               wmask;
   logic                     err;
   logic                     unused_addr_hi;

   // Address bits above the decoded range alias onto the same storage
   assign unused_addr_hi = ^req_addr[ADDRESS_WIDTH-1:MEM_ADDR_BITS];

   assign accept     = req_valid & req_ready;
   assign enter_resp = (next_state == RESP) && (state != RESP);

   // With zero wait states the access happens on the accepting edge, before the latch is loaded,
   // so in IDLE the live request drives the datapath and afterwards the latched copy does
   assign op_we     = (state == IDLE) ? req_we : we_q;
   assign op_addr   = (state == IDLE) ? req_addr[MEM_ADDR_BITS-1:0] : addr_q;
   assign op_wdata  = (state == IDLE) ? req_wdata : wdata_q;
   assign op_funct3 = (state == IDLE) ? req_funct3 : funct3_q;

   // State register and wait-state counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= next_state;
         if (accept) begin
            cnt <= CNT_INIT;
         end else if (state == WAIT && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
         end
      end
   end

   // Next-state decode
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (accept) next_state = (WAIT_STATES > 0) ? WAIT : RESP;
         WAIT:    if (cnt == 4'd0) next_state = RESP;
         RESP:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Outputs: handshake, response pulse and pipeline hold
   always_comb begin
      req_ready  = (state == IDLE) & ~rst;
      resp_valid = (state == RESP);
      resp_err   = (state == RESP) & err;
      resp_rdata = (state == RESP) ? rdata_q : '0;
      stall      = accept | (state == WAIT);
   end

   // Capture the request on acceptance so later input changes cannot affect it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         funct3_q <= 3'b000;
      end else if (accept) begin
         we_q     <= req_we;
         addr_q   <= req_addr[MEM_ADDR_BITS-1:0];
         wdata_q  <= req_wdata;
         funct3_q <= req_funct3;
      end
   end

   // Register the extended load result on the edge entering RESP
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata_q <= '0;
      end else if (enter_resp) begin
         rdata_q <= load_data;
      end
   end

   // Assemble the aligned word containing the addressed byte
   always_comb begin
      rword = '0;
      for (int b = 0; b < 4; b++) begin
         rword[8*b +: 8] = mem[{op_addr[MEM_ADDR_BITS-1:2], 2'(b)}];
      end
   end

   // Write the enabled byte lanes on the edge entering RESP; an aborting reset suppresses it
   always_ff @(posedge clk) begin
      if (!rst && enter_resp) begin
         for (int b = 0; b < 4; b++) begin
            if (wmask[b]) begin
               mem[{op_addr[MEM_ADDR_BITS-1:2], 2'(b)}] <= wlanes[8*b +: 8];
            end
         end
      end
   end

   lsu_align #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_align (
      .we     (op_we),
      .funct3 (op_funct3),
      .offset (op_addr[1:0]),
      .wdata  (op_wdata),
      .rword  (rword),
      .err    (err),
      .wmask  (wmask),
      .wlanes (wlanes),
      .rdata  (load_data)
   );

endmodule
